// File: rtl/axi_burst_loopback.sv
// AXI4 burst loopback: a master engine writes a fixed INCR burst into a word-indexed
// slave memory and reads it back into its own buffer over an internal AXI4 bundle.
module axi_burst_loopback #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_DEPTH = 64,
  parameter int BASE_ADDR = 4,
  parameter int BURST_LEN = 4,
  parameter logic [DATA_W-1:0] SEED = 32'hdeadbeef,
  localparam int IDX_W = $clog2(MEM_DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              start_write,
  input  logic              start_read,
  output logic              busy,
  output logic              write_done,
  output logic              read_done,
  output logic              bresp_err,
  input  logic [IDX_W-1:0]  dbg_index,
  output logic [DATA_W-1:0] dbg_slave_word,
  output logic [DATA_W-1:0] dbg_master_word
);

  localparam logic [7:0] LEN_M1 = 8'(BURST_LEN - 1);
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshake: a beat transfers when VALID && READY at a rising edge; VALID never
  // waits on READY, and once raised it holds with a stable payload until accepted.
  logic              awvalid, awready, arvalid, arready;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst;
  logic              wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_W-1:0] a,
                                                 input logic [7:0] b);
    logic [ADDR_W-1:0] s;
    s = a + ADDR_W'(b);
    return IDX_W'(s % ADDR_W'(MEM_DEPTH));
  endfunction

  // ---------------------------------------------------------------- master
  typedef enum logic [2:0] {
    M_IDLE, M_WADDR, M_WDATA, M_WRESP, M_RADDR, M_RDATA
  } m_state_t;

  m_state_t          m_state_q, m_state_d;
  logic [7:0]        m_beat_q, m_beat_d;
  logic              bresp_err_q;
  logic [DATA_W-1:0] rbuf_q [MEM_DEPTH];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      m_state_q <= M_IDLE;
      m_beat_q  <= '0;
    end else begin
      m_state_q <= m_state_d;
      m_beat_q  <= m_beat_d;
    end
  end

  always_comb begin
    m_state_d = m_state_q;
    m_beat_d  = m_beat_q;
    unique case (m_state_q)
      M_IDLE: begin
        m_beat_d = '0;
        if (start_write)     m_state_d = M_WADDR;
        else if (start_read) m_state_d = M_RADDR;
      end
      M_WADDR: if (awready) m_state_d = M_WDATA;
      M_WDATA: if (wready) begin
        m_beat_d = m_beat_q + 8'd1;
        if (wlast) m_state_d = M_WRESP;
      end
      M_WRESP: if (bvalid) m_state_d = M_IDLE;
      M_RADDR: if (arready) m_state_d = M_RDATA;
      M_RDATA: if (rvalid) begin
        m_beat_d = m_beat_q + 8'd1;
        if (rlast) m_state_d = M_IDLE;
      end
      default: m_state_d = M_IDLE;
    endcase
  end

  always_comb begin
    awvalid    = (m_state_q == M_WADDR);
    awaddr     = ADDR_W'(BASE_ADDR);
    awlen      = LEN_M1;
    awsize     = SIZE_W;
    awburst    = BURST_INCR;
    wvalid     = (m_state_q == M_WDATA);
    wdata      = SEED + DATA_W'(m_beat_q);
    wstrb      = '1;
    wlast      = wvalid && (m_beat_q == LEN_M1);
    bready     = (m_state_q == M_WRESP);
    arvalid    = (m_state_q == M_RADDR);
    araddr     = ADDR_W'(BASE_ADDR);
    arlen      = LEN_M1;
    arsize     = SIZE_W;
    arburst    = BURST_INCR;
    rready     = (m_state_q == M_RDATA);
    busy       = (m_state_q != M_IDLE);
    write_done = bready && bvalid;
    read_done  = rready && rvalid && rlast;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      bresp_err_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) rbuf_q[i] <= '0;
    end else begin
      if (rready && rvalid) rbuf_q[wrap_idx(araddr, m_beat_q)] <= rdata;
      if ((bready && bvalid && bresp != RESP_OKAY) ||
          (rready && rvalid && rresp != RESP_OKAY))
        bresp_err_q <= 1'b1;
    end
  end

  assign bresp_err       = bresp_err_q;
  assign dbg_master_word = rbuf_q[dbg_index];

  // ----------------------------------------------------------------- slave
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} s_state_t;

  s_state_t          s_state_q, s_state_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [7:0]        s_len_q, s_len_d, s_beat_q, s_beat_d;
  logic              s_bad_q, s_bad_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]  s_idx;

  assign s_idx = wrap_idx(s_addr_q, s_beat_q);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      s_state_q <= S_IDLE;
      s_addr_q  <= '0;
      s_len_q   <= '0;
      s_beat_q  <= '0;
      s_bad_q   <= 1'b0;
    end else begin
      s_state_q <= s_state_d;
      s_addr_q  <= s_addr_d;
      s_len_q   <= s_len_d;
      s_beat_q  <= s_beat_d;
      s_bad_q   <= s_bad_d;
    end
  end

  // Only word-sized INCR bursts are served cleanly; anything else answers SLVERR.
  always_comb begin
    s_state_d = s_state_q;
    s_addr_d  = s_addr_q;
    s_len_d   = s_len_q;
    s_beat_d  = s_beat_q;
    s_bad_d   = s_bad_q;
    unique case (s_state_q)
      S_IDLE: begin
        s_beat_d = '0;
        if (awvalid) begin
          s_addr_d  = awaddr;
          s_len_d   = awlen;
          s_bad_d   = (awsize != SIZE_W) || (awburst != BURST_INCR);
          s_state_d = S_WRITE;
        end else if (arvalid) begin
          s_addr_d  = araddr;
          s_len_d   = arlen;
          s_bad_d   = (arsize != SIZE_W) || (arburst != BURST_INCR);
          s_state_d = S_READ;
        end
      end
      S_WRITE: if (wvalid) begin
        s_beat_d = s_beat_q + 8'd1;
        if (s_beat_q == s_len_q) s_state_d = S_WRESP;
      end
      S_WRESP: if (bready) s_state_d = S_IDLE;
      S_READ: if (rready) begin
        s_beat_d = s_beat_q + 8'd1;
        if (s_beat_q == s_len_q) s_state_d = S_IDLE;
      end
      default: s_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    awready = (s_state_q == S_IDLE);
    arready = (s_state_q == S_IDLE) && !awvalid;
    wready  = (s_state_q == S_WRITE);
    bvalid  = (s_state_q == S_WRESP);
    bresp   = s_bad_q ? RESP_SLVERR : RESP_OKAY;
    rvalid  = (s_state_q == S_READ);
    rdata   = mem_q[s_idx];
    rresp   = s_bad_q ? RESP_SLVERR : RESP_OKAY;
    rlast   = rvalid && (s_beat_q == s_len_q);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wvalid && wready) begin
      for (int b = 0; b < STRB_W; b++)
        if (wstrb[b]) mem_q[s_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign dbg_slave_word = mem_q[dbg_index];

endmodule

// File: tb/tb_axi_burst_loopback.sv
// Directed bench for axi_burst_loopback: drives start pulses, waits for done pulses
// with cycle budgets and compares both memories against a scoreboard queue.
module tb_axi_burst_loopback;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        start_write = 1'b0;
  logic        start_read = 1'b0;
  logic        busy, write_done, read_done, bresp_err;
  logic [5:0]  dbg_index = '0;
  logic [31:0] dbg_slave_word, dbg_master_word;

  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  axi_burst_loopback dut (
    .aclk            (aclk),
    .areset_n        (areset_n),
    .start_write     (start_write),
    .start_read      (start_read),
    .busy            (busy),
    .write_done      (write_done),
    .read_done       (read_done),
    .bresp_err       (bresp_err),
    .dbg_index       (dbg_index),
    .dbg_slave_word  (dbg_slave_word),
    .dbg_master_word (dbg_master_word)
  );

  // ---- clock / reset
  always #5 aclk = ~aclk;

  task automatic do_reset();
    areset_n = 1'b0;
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
  endtask

  // ---- checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- drivers
  task automatic pulse(input bit wr, input bit rd);
    @(negedge aclk);
    start_write = wr;
    start_read  = rd;
    @(negedge aclk);
    start_write = 1'b0;
    start_read  = 1'b0;
  endtask

  // Returns the number of negedges until the pulse shows, or -1 if the budget runs out.
  task automatic wait_done(input bit is_read, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      if (i > 1) @(negedge aclk);
      #1;
      if ((is_read ? read_done : write_done) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // ---- scoreboard: expectations pushed with stimulus, popped after completion
  function automatic void push_burst(input bit zero);
    for (int i = 0; i < 4; i++) exp_q.push_back(zero ? 32'h0 : 32'hdeadbeef + i);
  endfunction

  task automatic drain_burst(input bit master, input string tag);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      dbg_index = 6'(4 + i);
      #1;
      check($sformatf("%s[%0d]", tag, 4 + i), master ? dbg_master_word : dbg_slave_word, e);
    end
  endtask

  task automatic peek(input bit master, input int idx, input string tag, input logic [31:0] e);
    dbg_index = 6'(idx);
    #1;
    check(tag, master ? dbg_master_word : dbg_slave_word, e);
  endtask

  int cyc;
  int pulses;

  initial begin
    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wdone", 32'(write_done), 32'd0);
    check("rst_rdone", 32'(read_done), 32'd0);
    check("rst_err", 32'(bresp_err), 32'd0);
    peek(1'b0, 4, "rst_slave4", 32'h0);
    peek(1'b1, 4, "rst_master4", 32'h0);

    // Write burst
    push_burst(1'b0);
    pulse(1'b1, 1'b0);
    wait_done(1'b0, 8, cyc);
    check("wr_latency_ok", 32'(cyc >= 1 && cyc <= 8), 32'd1);
    @(negedge aclk);
    drain_burst(1'b0, "wr_slave");
    peek(1'b0, 3, "wr_slave3", 32'h0);
    peek(1'b0, 8, "wr_slave8", 32'h0);

    // Read it back
    repeat (10) @(negedge aclk);
    push_burst(1'b0);
    pulse(1'b0, 1'b1);
    wait_done(1'b1, 8, cyc);
    check("rd_latency_ok", 32'(cyc >= 1 && cyc <= 8), 32'd1);
    @(negedge aclk);
    drain_burst(1'b1, "rd_master");
    check("rd_err", 32'(bresp_err), 32'd0);
    check("rd_busy", 32'(busy), 32'd0);

    // Read without a prior write
    do_reset();
    push_burst(1'b1);
    pulse(1'b0, 1'b1);
    wait_done(1'b1, 8, cyc);
    check("rd0_latency_ok", 32'(cyc >= 1 && cyc <= 8), 32'd1);
    @(negedge aclk);
    drain_burst(1'b1, "rd0_master");

    // Simultaneous start: the write wins, the read is dropped
    repeat ($urandom_range(1, 5)) @(negedge aclk);
    push_burst(1'b0);
    pulse(1'b1, 1'b1);
    wait_done(1'b0, 8, cyc);
    check("both_wr_ok", 32'(cyc >= 1 && cyc <= 8), 32'd1);
    @(negedge aclk);
    wait_done(1'b1, 12, cyc);
    check("both_no_rdone", 32'(cyc), 32'hffffffff);
    drain_burst(1'b0, "both_slave");
    peek(1'b1, 4, "both_master4", 32'h0);
    check("both_busy", 32'(busy), 32'd0);

    // Start while busy is ignored
    pulses = 0;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (write_done === 1'b1) pulses++;
      if (i == 1) begin
        check("busy_when_repulsed", 32'(busy), 32'd1);
        start_write = 1'b1;
      end else begin
        start_write = 1'b0;
      end
      @(negedge aclk);
    end
    check("single_wdone", 32'(pulses), 32'd1);

    // Reset in the middle of the write data phase
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge aclk);
    #1;
    check("mid_wvalid_pre", 32'(dut.wvalid), 32'd1);
    peek(1'b0, 4, "mid_slave4_pre", 32'hdeadbeef);
    areset_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_valids", {27'd0, dut.awvalid, dut.wvalid, dut.bvalid, dut.arvalid, dut.rvalid}, 32'd0);
    check("mid_wdone", 32'(write_done), 32'd0);
    peek(1'b0, 4, "mid_slave4", 32'h0);
    peek(1'b0, 5, "mid_slave5", 32'h0);
    peek(1'b1, 4, "mid_master4", 32'h0);
    @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
    push_burst(1'b0);
    pulse(1'b1, 1'b0);
    wait_done(1'b0, 8, cyc);
    check("post_wr_ok", 32'(cyc >= 1 && cyc <= 8), 32'd1);
    @(negedge aclk);
    drain_burst(1'b0, "post_slave");
    check("post_err", 32'(bresp_err), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
